// File: rtl/global_vel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : global_vel_arbiter
// Purpose  : Shares one GLOBAL_VELOCITY transform unit (local->global
//            velocity) between two requesters. Round-robin arbitration,
//            operand capture, unit start, watchdog-bounded wait for the
//            unit's done edge, result return with a per-requester done
//            pulse. Requests with theta outside [0, 180.0 deg] are
//            rejected without firing the unit.
// Ports    : CLOCK_50 / RESET_InLow   clock, async active-low reset
//            REQn_In / OPSn_InBus     level request + {THETA,WZ,VY,VX}
//            ACKn_Out                 operands captured (1-cycle pulse)
//            DONEn_Out                result valid (1-cycle pulse)
//            RES_OutBus / ERR_OutBus  {WZ,VY,VX} / {range_err,timeout_err}
//            BUSY_Out                 high whenever not idle
//            GV_READY_Out / GV_OPS    start pulse + operands to unit
//            GV_DONE_In / GV_RES      done flag + result from unit
// Revision : 1.0 - initial release
// ============================================================================
module global_vel_arbiter #(
    parameter int N_WIDTH        = 17,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 GLOBAL_VEL_ARBITER_CLOCK_50,
    input  logic                 GLOBAL_VEL_ARBITER_RESET_InLow,
    input  logic                 GLOBAL_VEL_ARBITER_REQ0_In,
    input  logic                 GLOBAL_VEL_ARBITER_REQ1_In,
    input  logic [4*N_WIDTH-1:0] GLOBAL_VEL_ARBITER_OPS0_InBus,
    input  logic [4*N_WIDTH-1:0] GLOBAL_VEL_ARBITER_OPS1_InBus,
    output logic                 GLOBAL_VEL_ARBITER_ACK0_Out,
    output logic                 GLOBAL_VEL_ARBITER_ACK1_Out,
    output logic                 GLOBAL_VEL_ARBITER_DONE0_Out,
    output logic                 GLOBAL_VEL_ARBITER_DONE1_Out,
    output logic [3*N_WIDTH-1:0] GLOBAL_VEL_ARBITER_RES_OutBus,
    output logic [1:0]           GLOBAL_VEL_ARBITER_ERR_OutBus,
    output logic                 GLOBAL_VEL_ARBITER_BUSY_Out,
    output logic                 GLOBAL_VEL_ARBITER_GV_READY_Out,
    output logic [4*N_WIDTH-1:0] GLOBAL_VEL_ARBITER_GV_OPS_OutBus,
    input  logic                 GLOBAL_VEL_ARBITER_GV_DONE_In,
    input  logic [3*N_WIDTH-1:0] GLOBAL_VEL_ARBITER_GV_RES_InBus
);

    // 180.0 degrees in U(N,8): integer part 180, eight fraction bits
    localparam logic [N_WIDTH-1:0] c_THETA_MAX = N_WIDTH'(180 * 256);
    localparam logic [7:0]         c_TIMEOUT   = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRE   = 3'd1,
        S_WAIT   = 3'd2,
        S_REJECT = 3'd3,
        S_RETURN = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_grant;      // requester currently being served
    logic                   r_rr_ptr;     // preferred requester on contention
    logic [7:0]             r_timer;
    logic                   r_done_prev;
    logic                   r_ack0;
    logic                   r_ack1;
    logic                   r_done0;
    logic                   r_done1;
    logic                   r_busy;
    logic                   r_gv_ready;
    logic [4*N_WIDTH-1:0]   r_gv_ops;
    logic [3*N_WIDTH-1:0]   r_res;
    logic [1:0]             r_err;

    logic                   w_any_req;
    logic                   w_pick;
    logic [4*N_WIDTH-1:0]   w_sel_ops;
    logic [N_WIDTH-1:0]     w_theta;
    logic                   w_theta_ok;
    logic                   w_done_edge;
    logic                   w_timer_hit;

    assign w_any_req   = GLOBAL_VEL_ARBITER_REQ0_In | GLOBAL_VEL_ARBITER_REQ1_In;
    // Contention goes to the round-robin pointer; otherwise the lone requester wins
    assign w_pick      = (GLOBAL_VEL_ARBITER_REQ0_In & GLOBAL_VEL_ARBITER_REQ1_In)
                         ? r_rr_ptr : GLOBAL_VEL_ARBITER_REQ1_In;
    assign w_sel_ops   = w_pick ? GLOBAL_VEL_ARBITER_OPS1_InBus
                                : GLOBAL_VEL_ARBITER_OPS0_InBus;
    assign w_theta     = w_sel_ops[4*N_WIDTH-1:3*N_WIDTH];
    assign w_theta_ok  = !w_theta[N_WIDTH-1] && (w_theta <= c_THETA_MAX);
    // A done level already present when WAIT starts is stale; only a fresh
    // rising edge counts as completion
    assign w_done_edge = GLOBAL_VEL_ARBITER_GV_DONE_In & ~r_done_prev;
    assign w_timer_hit = (r_timer == c_TIMEOUT);

    always_ff @(posedge GLOBAL_VEL_ARBITER_CLOCK_50 or negedge GLOBAL_VEL_ARBITER_RESET_InLow) begin
        if (!GLOBAL_VEL_ARBITER_RESET_InLow) begin
            r_state     <= S_IDLE;
            r_grant     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_timer     <= 8'd0;
            r_done_prev <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_busy      <= 1'b0;
            r_gv_ready  <= 1'b0;
            r_gv_ops    <= '0;
            r_res       <= '0;
            r_err       <= 2'b00;
        end else begin
            // Edge history tracks the unit in every state
            r_done_prev <= GLOBAL_VEL_ARBITER_GV_DONE_In;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_gv_ready  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant  <= w_pick;
                        r_gv_ops <= w_sel_ops;
                        r_busy   <= 1'b1;
                        r_ack0   <= ~w_pick;
                        r_ack1   <= w_pick;
                        if (w_theta_ok) begin
                            r_gv_ready <= 1'b1;
                            r_timer    <= 8'd0;
                            r_state    <= S_FIRE;
                        end else begin
                            r_state    <= S_REJECT;
                        end
                    end
                end

                S_FIRE: begin
                    r_timer <= 8'd0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (w_done_edge) begin
                        // Completion takes priority over a coincident timeout
                        r_res   <= GLOBAL_VEL_ARBITER_GV_RES_InBus;
                        r_err   <= 2'b00;
                        r_done0 <= ~r_grant;
                        r_done1 <= r_grant;
                        r_state <= S_RETURN;
                    end else if (w_timer_hit) begin
                        r_res   <= '0;
                        r_err   <= 2'b01;
                        r_done0 <= ~r_grant;
                        r_done1 <= r_grant;
                        r_state <= S_RETURN;
                    end else if (r_timer != 8'hFF) begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                S_REJECT: begin
                    r_res   <= '0;
                    r_err   <= 2'b10;
                    r_done0 <= ~r_grant;
                    r_done1 <= r_grant;
                    r_state <= S_RETURN;
                end

                S_RETURN: begin
                    r_rr_ptr <= ~r_grant;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign GLOBAL_VEL_ARBITER_ACK0_Out      = r_ack0;
    assign GLOBAL_VEL_ARBITER_ACK1_Out      = r_ack1;
    assign GLOBAL_VEL_ARBITER_DONE0_Out     = r_done0;
    assign GLOBAL_VEL_ARBITER_DONE1_Out     = r_done1;
    assign GLOBAL_VEL_ARBITER_RES_OutBus    = r_res;
    assign GLOBAL_VEL_ARBITER_ERR_OutBus    = r_err;
    assign GLOBAL_VEL_ARBITER_BUSY_Out      = r_busy;
    assign GLOBAL_VEL_ARBITER_GV_READY_Out  = r_gv_ready;
    assign GLOBAL_VEL_ARBITER_GV_OPS_OutBus = r_gv_ops;

endmodule
`default_nettype wire

// File: tb/tb_global_vel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_global_vel_arbiter
// Purpose  : Directed self-checking bench for global_vel_arbiter. Instance
//            dut uses the default watchdog; instance dut_b uses a 10-cycle
//            watchdog for the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_global_vel_arbiter;

    localparam int N = 17;

    logic           clk = 1'b0;
    logic           rst_n;

    logic           req0, req1, gv_done;
    logic [4*N-1:0] ops0, ops1, gv_ops;
    logic [3*N-1:0] res, gv_res;
    logic [1:0]     err;
    logic           ack0, ack1, done0, done1, busy, gv_ready;

    logic           b_req0, b_req1, b_gv_done;
    logic [4*N-1:0] b_ops0, b_ops1, b_gv_ops;
    logic [3*N-1:0] b_res, b_gv_res;
    logic [1:0]     b_err;
    logic           b_ack0, b_ack1, b_done0, b_done1, b_busy, b_gv_ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    global_vel_arbiter #(.N_WIDTH(N), .TIMEOUT_CYCLES(255)) dut (
        .GLOBAL_VEL_ARBITER_CLOCK_50     (clk),
        .GLOBAL_VEL_ARBITER_RESET_InLow  (rst_n),
        .GLOBAL_VEL_ARBITER_REQ0_In      (req0),
        .GLOBAL_VEL_ARBITER_REQ1_In      (req1),
        .GLOBAL_VEL_ARBITER_OPS0_InBus   (ops0),
        .GLOBAL_VEL_ARBITER_OPS1_InBus   (ops1),
        .GLOBAL_VEL_ARBITER_ACK0_Out     (ack0),
        .GLOBAL_VEL_ARBITER_ACK1_Out     (ack1),
        .GLOBAL_VEL_ARBITER_DONE0_Out    (done0),
        .GLOBAL_VEL_ARBITER_DONE1_Out    (done1),
        .GLOBAL_VEL_ARBITER_RES_OutBus   (res),
        .GLOBAL_VEL_ARBITER_ERR_OutBus   (err),
        .GLOBAL_VEL_ARBITER_BUSY_Out     (busy),
        .GLOBAL_VEL_ARBITER_GV_READY_Out (gv_ready),
        .GLOBAL_VEL_ARBITER_GV_OPS_OutBus(gv_ops),
        .GLOBAL_VEL_ARBITER_GV_DONE_In   (gv_done),
        .GLOBAL_VEL_ARBITER_GV_RES_InBus (gv_res)
    );

    global_vel_arbiter #(.N_WIDTH(N), .TIMEOUT_CYCLES(10)) dut_b (
        .GLOBAL_VEL_ARBITER_CLOCK_50     (clk),
        .GLOBAL_VEL_ARBITER_RESET_InLow  (rst_n),
        .GLOBAL_VEL_ARBITER_REQ0_In      (b_req0),
        .GLOBAL_VEL_ARBITER_REQ1_In      (b_req1),
        .GLOBAL_VEL_ARBITER_OPS0_InBus   (b_ops0),
        .GLOBAL_VEL_ARBITER_OPS1_InBus   (b_ops1),
        .GLOBAL_VEL_ARBITER_ACK0_Out     (b_ack0),
        .GLOBAL_VEL_ARBITER_ACK1_Out     (b_ack1),
        .GLOBAL_VEL_ARBITER_DONE0_Out    (b_done0),
        .GLOBAL_VEL_ARBITER_DONE1_Out    (b_done1),
        .GLOBAL_VEL_ARBITER_RES_OutBus   (b_res),
        .GLOBAL_VEL_ARBITER_ERR_OutBus   (b_err),
        .GLOBAL_VEL_ARBITER_BUSY_Out     (b_busy),
        .GLOBAL_VEL_ARBITER_GV_READY_Out (b_gv_ready),
        .GLOBAL_VEL_ARBITER_GV_OPS_OutBus(b_gv_ops),
        .GLOBAL_VEL_ARBITER_GV_DONE_In   (b_gv_done),
        .GLOBAL_VEL_ARBITER_GV_RES_InBus (b_gv_res)
    );

    function automatic logic [4*N-1:0] mk_ops(input logic [N-1:0] th, input logic [N-1:0] wz,
                                              input logic [N-1:0] vy, input logic [N-1:0] vx);
        return {th, wz, vy, vx};
    endfunction

    function automatic logic [3*N-1:0] mk_res(input logic [N-1:0] wz, input logic [N-1:0] vy,
                                              input logic [N-1:0] vx);
        return {wz, vy, vx};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [4*N-1:0] ops_a, ops_b;
        logic [3*N-1:0] res_exp;
        logic [N-1:0]   theta;
        logic           seen;
        logic           g;

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; ops0 = '0; ops1 = '0; gv_done = 1'b0; gv_res = '0;
        b_req0 = 1'b0; b_req1 = 1'b0; b_ops0 = '0; b_ops1 = '0; b_gv_done = 1'b0; b_gv_res = '0;
        step(2);

        // ---------------- reset state ----------------
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_done0", done0, 1'b0);
        chk1("rst_done1", done1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_gv_ready", gv_ready, 1'b0);
        chkw("rst_res", 128'(res), 128'(0));
        chkw("rst_err", 128'(err), 128'(0));
        chkw("rst_gv_ops", 128'(gv_ops), 128'(0));
        rst_n = 1'b1;
        step(1);

        // ---------------- 1: single req0 ----------------
        ops_a = mk_ops(17'h05A00, 17'h00080, 17'h00000, 17'h00100);
        req0 = 1'b1; ops0 = ops_a;
        step(1);
        chk1("t1_ack0", ack0, 1'b1);
        chk1("t1_gv_ready", gv_ready, 1'b1);
        chk1("t1_ack1", ack1, 1'b0);
        chk1("t1_busy", busy, 1'b1);
        chkw("t1_gv_ops", 128'(gv_ops), 128'(ops_a));
        req0 = 1'b0; ops0 = '0;
        step(1);
        chk1("t1_ready_pulse", gv_ready, 1'b0);
        chkw("t1_ops_held", 128'(gv_ops), 128'(ops_a));
        seen = 1'b0;
        for (int i = 0; i < 19; i++) begin
            step(1);
            seen = seen | done0 | done1 | ack0 | ack1 | gv_ready;
        end
        chk1("t1_quiet_wait", seen, 1'b0);
        res_exp = mk_res(17'h00080, 17'h00000, 17'h00100);
        gv_done = 1'b1; gv_res = res_exp;
        step(1);
        chk1("t1_done0", done0, 1'b1);
        chk1("t1_done1", done1, 1'b0);
        chkw("t1_res", 128'(res), 128'(res_exp));
        chkw("t1_err", 128'(err), 128'(2'b00));
        gv_done = 1'b0; gv_res = '0;
        step(1);
        chk1("t1_done0_pulse", done0, 1'b0);
        chk1("t1_idle_busy", busy, 1'b0);
        chkw("t1_res_held", 128'(res), 128'(res_exp));

        // ---------------- 2: contention, round robin ----------------
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        ops_a = mk_ops(17'h02D00, 17'h00010, 17'h00020, 17'h00030);
        ops_b = mk_ops(17'h07800, 17'h00011, 17'h00021, 17'h00031);
        req0 = 1'b1; req1 = 1'b1; ops0 = ops_a; ops1 = ops_b;
        for (int t = 0; t < 4; t++) begin
            g = t[0];
            step(1);
            chk1("t2_ack0", ack0, !g);
            chk1("t2_ack1", ack1, g);
            chkw("t2_gv_ops", 128'(gv_ops), g ? 128'(ops_b) : 128'(ops_a));
            step(1);
            res_exp = mk_res(17'(t + 1), 17'(t + 5), 17'(t + 9));
            gv_done = 1'b1; gv_res = res_exp;
            step(1);
            chk1("t2_done0", done0, !g);
            chk1("t2_done1", done1, g);
            chkw("t2_res", 128'(res), 128'(res_exp));
            gv_done = 1'b0;
            step(1);
        end
        req0 = 1'b0; req1 = 1'b0;

        // ---------------- 3: out-of-range theta rejected ----------------
        for (int k = 0; k < 2; k++) begin
            theta = (k == 0) ? 17'h0B500 : 17'h10100;
            req1 = 1'b1; ops1 = mk_ops(theta, 17'h00001, 17'h00002, 17'h00003);
            step(1);
            chk1("t3_ack1", ack1, 1'b1);
            chk1("t3_no_ready_a", gv_ready, 1'b0);
            req1 = 1'b0;
            step(1);
            chk1("t3_done1", done1, 1'b1);
            chk1("t3_no_ready_b", gv_ready, 1'b0);
            chkw("t3_err", 128'(err), 128'(2'b10));
            chkw("t3_res", 128'(res), 128'(0));
            step(1);
        end

        // ---------------- 4: watchdog timeout (dut_b, 10 cycles) ----------------
        b_req1 = 1'b1; b_ops1 = mk_ops(17'h01000, 17'h00004, 17'h00005, 17'h00006);
        step(1);
        chk1("t4_pre_ack1", b_ack1, 1'b1);
        b_req1 = 1'b0;
        step(1);
        res_exp = mk_res(17'h00111, 17'h00222, 17'h00333);
        b_gv_done = 1'b1; b_gv_res = res_exp;
        step(1);
        chk1("t4_pre_done1", b_done1, 1'b1);
        chkw("t4_pre_res", 128'(b_res), 128'(res_exp));
        b_gv_done = 1'b0;
        step(1);
        b_req0 = 1'b1; b_ops0 = mk_ops(17'h03000, 17'h00007, 17'h00008, 17'h00009);
        step(1);
        chk1("t4_gv_ready", b_gv_ready, 1'b1);
        b_req0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(1);
            seen = seen | b_done0 | b_done1;
        end
        chk1("t4_no_early_done", seen, 1'b0);
        step(1);
        chk1("t4_done0", b_done0, 1'b1);
        chkw("t4_err", 128'(b_err), 128'(2'b01));
        chkw("t4_res", 128'(b_res), 128'(0));
        step(1);
        b_req1 = 1'b1; b_ops1 = mk_ops(17'h00100, 17'h0000A, 17'h0000B, 17'h0000C);
        step(1);
        chk1("t4_next_ack1", b_ack1, 1'b1);
        chk1("t4_next_ready", b_gv_ready, 1'b1);
        b_req1 = 1'b0;
        step(1);
        res_exp = mk_res(17'h00444, 17'h00555, 17'h00666);
        b_gv_done = 1'b1; b_gv_res = res_exp;
        step(1);
        chk1("t4_next_done1", b_done1, 1'b1);
        chkw("t4_next_err", 128'(b_err), 128'(2'b00));
        chkw("t4_next_res", 128'(b_res), 128'(res_exp));
        b_gv_done = 1'b0;
        step(1);

        // ---------------- 5: stale done level, theta boundary ----------------
        gv_done = 1'b1;
        step(1);
        ops_a = mk_ops(17'h0B400, 17'h00040, 17'h00050, 17'h00060);
        req0 = 1'b1; ops0 = ops_a;
        step(1);
        chk1("t5_ack0", ack0, 1'b1);
        chk1("t5_boundary_ready", gv_ready, 1'b1);
        req0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            seen = seen | done0 | done1;
        end
        chk1("t5_stale_ignored", seen, 1'b0);
        gv_done = 1'b0;
        step(1);
        chk1("t5_fall_no_done", done0, 1'b0);
        res_exp = mk_res(17'h00777, 17'h00888, 17'h00999);
        gv_done = 1'b1; gv_res = res_exp;
        step(1);
        chk1("t5_done0", done0, 1'b1);
        chkw("t5_res", 128'(res), 128'(res_exp));
        gv_done = 1'b0;
        step(1);

        // ---------------- 6: async reset during WAIT ----------------
        req1 = 1'b1; ops1 = mk_ops(17'h01000, 17'h00001, 17'h00001, 17'h00001);
        step(1);
        chk1("t6_ack1", ack1, 1'b1);
        req1 = 1'b0;
        step(3);
        rst_n = 1'b0;
        #2;
        chk1("t6_async_busy", busy, 1'b0);
        chkw("t6_async_res", 128'(res), 128'(0));
        chkw("t6_async_gv_ops", 128'(gv_ops), 128'(0));
        step(1);
        chk1("t6_no_done1", done1, 1'b0);
        rst_n = 1'b1;
        ops_a = mk_ops(17'h00200, 17'h00012, 17'h00013, 17'h00014);
        ops_b = mk_ops(17'h00300, 17'h00015, 17'h00016, 17'h00017);
        req0 = 1'b1; req1 = 1'b1; ops0 = ops_a; ops1 = ops_b;
        step(1);
        chk1("t6_grant_ack0", ack0, 1'b1);
        chk1("t6_grant_ack1", ack1, 1'b0);
        chkw("t6_grant_ops", 128'(gv_ops), 128'(ops_a));
        req0 = 1'b0; req1 = 1'b0;
        step(1);
        gv_done = 1'b1; gv_res = mk_res(17'h00001, 17'h00002, 17'h00003);
        step(1);
        chk1("t6_done0", done0, 1'b1);
        gv_done = 1'b0;
        step(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
